// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared codes, state encodings and defaults for the command-link UART
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 5208;

    localparam logic [3:0] INST_LIMPA   = 4'd1;
    localparam logic [3:0] INST_CARREGA = 4'd2;
    localparam logic [3:0] INST_MOSTRA  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;

    function automatic logic is_legal_inst(input logic [3:0] inst);
        return (inst == INST_LIMPA) || (inst == INST_CARREGA) || (inst == INST_MOSTRA);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - reloadable bit-period down-counter, shared by transmitter and receiver
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load || o_bit_end) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_bit_end = (r_count == '0);

endmodule

// File: rtl/uart_cmd_tx.sv
// rtl/uart_cmd_tx.sv - 8N1 command transmitter packing {instruction, operand} with a one-entry holding register
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [3:0] instrucao,
    input  logic [3:0] dado,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] estado
);

    localparam logic LAST_STOP = (STOP_BITS == 2);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_shift;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [2:0] r_idx;
    logic       r_stop_idx;
    logic       r_tx;
    logic       r_err;
    logic       w_bit_end;
    logic       w_accept;
    logic       w_frame_end;
    logic [7:0] w_byte;

    assign w_byte      = {instrucao, dado};
    assign w_accept    = send && !r_hold_full && is_legal_inst(instrucao);
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_stop_idx == LAST_STOP);

    // Held at reload while idle so START always gets a full bit period.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == ST_IDLE),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_START;
            ST_START: if (w_bit_end) w_next = ST_DATA;
            ST_DATA:  if (w_bit_end && (r_idx == 3'd7)) w_next = ST_STOP;
            ST_STOP:  if (w_frame_end) w_next = (r_hold_full || w_accept) ? ST_START : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != ST_IDLE);
        done   = w_frame_end;
        ready  = !r_hold_full;
        estado = r_state;
    end

    assign tx  = r_tx;
    assign err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= 1'b1;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_idx       <= '0;
            r_stop_idx  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= send && !r_hold_full && !is_legal_inst(instrucao);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift <= w_byte;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx  <= r_shift[0];
                        r_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_frame_end) begin
                        if (r_hold_full) begin
                            r_shift     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_tx        <= 1'b0;
                        end else if (w_accept) begin
                            r_shift <= w_byte;
                            r_tx    <= 1'b0;
                        end
                    end else if (w_bit_end) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: r_tx <= 1'b1;
            endcase
            // A command arriving mid-frame waits in the holding register.
            if (w_accept && (r_state != ST_IDLE) && !w_frame_end) begin
                r_hold      <= w_byte;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb/tb_uart_cmd_tx.sv - directed bench for uart_cmd_tx with a mid-bit sampling receiver scoreboard
module tb_uart_cmd_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, send1, ready1, tx1, busy1, done1, err1;
    logic [3:0] ins1, dat1;
    logic [2:0] est1;
    logic       rst2, send2, ready2, tx2, busy2, done2, err2;
    logic [3:0] ins2, dat2;
    logic [2:0] est2;

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst1), .send(send1), .instrucao(ins1), .dado(dat1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1), .err(err1), .estado(est1)
    );

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst2), .send(send2), .instrucao(ins2), .dado(dat2),
        .ready(ready2), .tx(tx2), .busy(busy2), .done(done2), .err(err2), .estado(est2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         rx_k = 0;
    logic [7:0] rx_byte = '0;

    always @(negedge clk) begin
        if (rst1 === 1'b1) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx1 === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_k = rx_cnt / CPB;
                if (rx_k == 0) begin
                    check("rx_start", {31'd0, tx1}, 32'd0);
                end else if (rx_k <= 8) begin
                    rx_byte[3'(rx_k - 1)] = tx1;
                end else begin
                    check("rx_stop", {31'd0, tx1}, 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic sb_check();
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    logic [9:0]  bits_29 = 10'h252;
    logic [9:0]  bits_1f;
    logic [10:0] bits_40_2stop = 11'h680;
    int          done_cnt;

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        send1 = 1'b0; ins1 = '0; dat1 = '0;
        send2 = 1'b0; ins2 = '0; dat2 = '0;
        bits_1f = 10'h23e;
        step();
        step();
        check("rst_tx", {31'd0, tx1}, 32'd1);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_err", {31'd0, err1}, 32'd0);
        check("rst_ready", {31'd0, ready1}, 32'd1);
        check("rst_estado", {29'd0, est1}, 32'd0);
        check("rst2_tx", {31'd0, tx2}, 32'd1);
        rst1 = 1'b0; rst2 = 1'b0;
        step();

        // 1: single frame 8'h29
        ins1 = 4'd2; dat1 = 4'd9; send1 = 1'b1;
        step();
        send1 = 1'b0;
        exp_q.push_back(8'h29);
        for (int j = 0; j < 40; j++) begin
            check("t1_tx", {31'd0, tx1}, {31'd0, bits_29[j / 4]});
            check("t1_done", {31'd0, done1}, (j == 39) ? 32'd1 : 32'd0);
            check("t1_busy", {31'd0, busy1}, 32'd1);
            if (j == 0)  check("t1_est_start", {29'd0, est1}, 32'd1);
            if (j == 4)  check("t1_est_data", {29'd0, est1}, 32'd2);
            if (j == 36) check("t1_est_stop", {29'd0, est1}, 32'd3);
            step();
        end
        check("t1_end_est", {29'd0, est1}, 32'd0);
        check("t1_end_busy", {31'd0, busy1}, 32'd0);
        check("t1_end_ready", {31'd0, ready1}, 32'd1);
        check("t1_end_done", {31'd0, done1}, 32'd0);
        sb_check();

        // 2: illegal instruction 3
        ins1 = 4'd3; dat1 = 4'd5; send1 = 1'b1;
        step();
        send1 = 1'b0;
        check("t2_err", {31'd0, err1}, 32'd1);
        check("t2_tx", {31'd0, tx1}, 32'd1);
        check("t2_ready", {31'd0, ready1}, 32'd1);
        check("t2_busy", {31'd0, busy1}, 32'd0);
        check("t2_est", {29'd0, est1}, 32'd0);
        step();
        check("t2_err_clr", {31'd0, err1}, 32'd0);
        check("t2_busy2", {31'd0, busy1}, 32'd0);

        // 3: 8'h1F then 8'h47 queued at cycle 10
        ins1 = 4'd1; dat1 = 4'hF; send1 = 1'b1;
        step();
        send1 = 1'b0;
        exp_q.push_back(8'h1F);
        exp_q.push_back(8'h47);
        for (int j = 0; j < 80; j++) begin
            check("t3_ready", {31'd0, ready1}, (j >= 10 && j <= 39) ? 32'd0 : 32'd1);
            check("t3_done", {31'd0, done1}, (j == 39 || j == 79) ? 32'd1 : 32'd0);
            check("t3_busy", {31'd0, busy1}, 32'd1);
            if (j < 40) check("t3_tx1", {31'd0, tx1}, {31'd0, bits_1f[j / 4]});
            if (j == 40) check("t3_b2b_tx", {31'd0, tx1}, 32'd0);
            if (j == 40) check("t3_b2b_est", {29'd0, est1}, 32'd1);
            if (j == 9) begin
                ins1 = 4'd4; dat1 = 4'd7; send1 = 1'b1;
            end
            if (j == 10) begin
                send1 = 1'b0;
                ins1 = 4'd0; dat1 = 4'd0;
            end
            step();
        end
        check("t3_end_busy", {31'd0, busy1}, 32'd0);
        sb_check();

        // 4: send held high for 40 cycles
        ins1 = 4'd4; dat1 = 4'hA; send1 = 1'b1;
        step();
        exp_q.push_back(8'h4A);
        exp_q.push_back(8'h4A);
        done_cnt = 0;
        for (int j = 0; j < 80; j++) begin
            check("t4_err", {31'd0, err1}, 32'd0);
            check("t4_ready", {31'd0, ready1}, (j >= 1 && j <= 39) ? 32'd0 : 32'd1);
            if (done1 === 1'b1) done_cnt++;
            if (j == 39) send1 = 1'b0;
            step();
        end
        check("t4_done_cnt", done_cnt, 32'd2);
        check("t4_end_busy", {31'd0, busy1}, 32'd0);
        sb_check();

        // 5: reset at cycle 17 with a held command pending
        ins1 = 4'd2; dat1 = 4'd4; send1 = 1'b1;
        step();
        send1 = 1'b0;
        for (int j = 0; j < 17; j++) begin
            if (j == 3) check("t5_ready_held", {31'd0, ready1}, 32'd0);
            if (j == 2) begin
                ins1 = 4'd1; dat1 = 4'd3; send1 = 1'b1;
            end
            if (j == 3) send1 = 1'b0;
            if (j == 16) rst1 = 1'b1;
            if (j < 16) step();
        end
        step();
        check("t5_tx", {31'd0, tx1}, 32'd1);
        check("t5_busy", {31'd0, busy1}, 32'd0);
        check("t5_ready", {31'd0, ready1}, 32'd1);
        check("t5_est", {29'd0, est1}, 32'd0);
        check("t5_done", {31'd0, done1}, 32'd0);
        rst1 = 1'b0;
        ins1 = 4'd1; dat1 = 4'd2; send1 = 1'b1;
        step();
        send1 = 1'b0;
        exp_q.push_back(8'h12);
        check("t5_restart_tx", {31'd0, tx1}, 32'd0);
        for (int j = 0; j < 45; j++) step();
        check("t5_end_busy", {31'd0, busy1}, 32'd0);
        sb_check();

        // 6: two stop bits, 8'h40
        ins2 = 4'd4; dat2 = 4'd0; send2 = 1'b1;
        step();
        send2 = 1'b0;
        for (int j = 0; j < 44; j++) begin
            check("t6_tx", {31'd0, tx2}, {31'd0, bits_40_2stop[j / 4]});
            check("t6_done", {31'd0, done2}, (j == 43) ? 32'd1 : 32'd0);
            step();
        end
        check("t6_end_est", {29'd0, est2}, 32'd0);
        check("t6_end_busy", {31'd0, busy2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
